// File: rtl/md_unit_if.sv
// Bus between the E-stage datapath/hazard logic and the multiply/divide unit.
// The master drives operation requests; the slave (md_unit) returns the read data and the busy/stall status.
interface md_unit_if;
  logic        start;
  logic [2:0]  MDop;
  logic [31:0] A;
  logic [31:0] B;
  logic        HIsel;
  logic        MDuse_D;
  logic [31:0] MDout;
  logic        Busy;
  logic        MDstall;

  modport master (
    output start, MDop, A, B, HIsel, MDuse_D,
    input  MDout, Busy, MDstall
  );

  modport slave (
    input  start, MDop, A, B, HIsel, MDuse_D,
    output MDout, Busy, MDstall
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and busy/stall sequencing.
// Optional feature: define MDU_CANCEL_EN to add a Cancel port that aborts an in-flight operation.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_unit_if.slave md
`ifdef MDU_CANCEL_EN
  ,
  input  logic Cancel
`endif
);

  logic [31:0] hi, lo, pend_hi, pend_lo;
  logic [31:0] hi_n, lo_n, pend_hi_n, pend_lo_n;
  logic        pend_keep, pend_keep_n;
  logic [3:0]  cnt, cnt_n;
  logic        busy, arith_op, accept, cancel;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor, a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

`ifdef MDU_CANCEL_EN
  assign cancel = Cancel;
`else
  assign cancel = 1'b0;
`endif

  assign busy     = (cnt != 4'd0);
  assign arith_op = (md.MDop >= 3'd1) && (md.MDop <= 3'd4);
  assign accept   = md.start && !busy && !cancel;

  assign md.Busy    = busy;
  assign md.MDout   = md.HIsel ? hi : lo;
  assign md.MDstall = md.MDuse_D && (busy || (md.start && arith_op));

  assign prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
  assign prod_u = {32'd0, md.A} * {32'd0, md.B};

  // Zero divisor is replaced by 1 to keep the divider defined; the result is discarded anyway.
  assign divisor = (md.B == 32'd0) ? 32'd1 : md.B;
  assign a_mag   = md.A[31] ? (32'd0 - md.A) : md.A;
  assign b_mag   = divisor[31] ? (32'd0 - divisor) : divisor;
  assign q_mag   = a_mag / b_mag;
  assign r_mag   = a_mag % b_mag;
  // Magnitude division makes 0x80000000 / -1 wrap to 0x80000000 with remainder 0.
  assign q_s     = (md.A[31] ^ divisor[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s     = md.A[31] ? (32'd0 - r_mag) : r_mag;
  assign q_u     = md.A / divisor;
  assign r_u     = md.A % divisor;

  always_comb begin
    hi_n        = hi;
    lo_n        = lo;
    pend_hi_n   = pend_hi;
    pend_lo_n   = pend_lo;
    pend_keep_n = pend_keep;
    cnt_n       = cnt;

    if (busy) begin
      cnt_n = cnt - 4'd1;
      if (cnt == 4'd1 && !pend_keep) begin
        hi_n = pend_hi;
        lo_n = pend_lo;
      end
    end

    if (accept) begin
      case (md.MDop)
        3'd1: begin
          {pend_hi_n, pend_lo_n} = prod_s;
          pend_keep_n = 1'b0;
          cnt_n       = 4'(MULT_CYCLES);
        end
        3'd2: begin
          {pend_hi_n, pend_lo_n} = prod_u;
          pend_keep_n = 1'b0;
          cnt_n       = 4'(MULT_CYCLES);
        end
        3'd3: begin
          pend_hi_n   = r_s;
          pend_lo_n   = q_s;
          pend_keep_n = (md.B == 32'd0);
          cnt_n       = 4'(DIV_CYCLES);
        end
        3'd4: begin
          pend_hi_n   = r_u;
          pend_lo_n   = q_u;
          pend_keep_n = (md.B == 32'd0);
          cnt_n       = 4'(DIV_CYCLES);
        end
        3'd5:    hi_n = md.A;
        3'd6:    lo_n = md.A;
        default: ;
      endcase
    end

    if (cancel) begin
      cnt_n = 4'd0;
      hi_n  = hi;
      lo_n  = lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi        <= 32'd0;
      lo        <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_keep <= 1'b0;
      cnt       <= 4'd0;
    end else begin
      hi        <= hi_n;
      lo        <= lo_n;
      pend_hi   <= pend_hi_n;
      pend_lo   <= pend_lo_n;
      pend_keep <= pend_keep_n;
      cnt       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed plus randomized bench for md_unit against a cycle-timeline reference model.
module tb_md_unit;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MDU_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic cancel;
  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
`ifdef MDU_CANCEL_EN
    ,
    .Cancel(cancel)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural HI/LO plus one outstanding op on an absolute cycle timeline.
  int          c = 0;
  int          t0 = 0;
  int          n_lat = 0;
  bit          active = 0;
  bit          keep = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic [31:0] last_out;
  logic        last_busy, last_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb, q, r;
    longint      ps;
    logic [63:0] pu;
    sa = a;
    sb = b;
    case (op)
      3'd1: begin ps = longint'(sa) * longint'(sb); return ps; end
      3'd2: begin pu = 64'(a) * 64'(b); return pu; end
      3'd3: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  task automatic step(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic use_d, input logic hs, input logic cn, input logic rs);
    logic        exp_busy, exp_stall, cx;
    logic [31:0] exp_out;
    bus.start = st; bus.MDop = op; bus.A = a; bus.B = b;
    bus.MDuse_D = use_d; bus.HIsel = hs; cancel = cn; reset = rs;
    @(negedge clk);
    exp_busy  = active && (c >= t0 + 1) && (c <= t0 + n_lat);
    exp_stall = use_d && (exp_busy || (st && op >= 3'd1 && op <= 3'd4));
    exp_out   = hs ? m_hi : m_lo;
    chk("busy", 32'(bus.Busy), 32'(exp_busy));
    chk("mdstall", 32'(bus.MDstall), 32'(exp_stall));
    chk("mdout", bus.MDout, exp_out);
    last_out = bus.MDout; last_busy = bus.Busy; last_stall = bus.MDstall;
    @(posedge clk);
    #1;
    cx = CANCEL_EN && cn;
    if (rs) begin
      m_hi = 0; m_lo = 0; active = 0;
    end else if (cx) begin
      active = 0;
    end else begin
      if (active && c == t0 + n_lat) begin
        if (!keep) begin m_hi = p_hi; m_lo = p_lo; end
        active = 0;
      end
      if (st && !exp_busy) begin
        if (op >= 3'd1 && op <= 3'd4) begin
          {p_hi, p_lo} = ref_result(op, a, b);
          keep   = (op >= 3'd3) && (b == 32'd0);
          active = 1;
          t0     = c;
          n_lat  = (op <= 3'd2) ? MULT_N : DIV_N;
        end else if (op == 3'd5) m_hi = a;
        else if (op == 3'd6) m_lo = a;
      end
    end
    c++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, 32'd0, 32'd0, 0, 0, 0, 0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int wait_n);
    step(1, op, a, b, 0, 0, 0, 0);
    idle(wait_n);
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    step(0, 3'd0, 32'd0, 32'd0, 0, 1, 0, 0);
    h = last_out;
    step(0, 3'd0, 32'd0, 32'd0, 0, 0, 0, 0);
    l = last_out;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] h, l, h0, l0;

  initial begin
    bus.start = 0; bus.MDop = 0; bus.A = 0; bus.B = 0; bus.MDuse_D = 0; bus.HIsel = 0;
    cancel = 0; reset = 1;
    @(posedge clk);
    #1;
    step(0, 3'd0, 32'd0, 32'd0, 0, 1, 0, 1);
    chk("reset_hi", last_out, 32'd0);
    chk("reset_busy", 32'(last_busy), 32'd0);
    step(1, 3'd1, 32'd0, 32'd0, 1, 0, 0, 1);
    chk("reset_stall_start", 32'(last_stall), 32'd1);

    // mult -3 * 5
    step(1, 3'd1, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, 0);
    chk("mult_busy_t0", 32'(last_busy), 32'd0);
    idle(1);
    chk("mult_busy_t1", 32'(last_busy), 32'd1);
    idle(4);
    chk("mult_busy_t5", 32'(last_busy), 32'd1);
    read_hilo(h, l);
    chk("mult_busy_t6", 32'(dut.busy), 32'd0);
    chk("mult_hi", h, 32'hFFFF_FFFF);
    chk("mult_lo", l, 32'hFFFF_FFF1);

    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, MULT_N);
    read_hilo(h, l);
    chk("multu_hi", h, 32'h0000_0001);
    chk("multu_lo", l, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, MULT_N);
    read_hilo(h, l);
    chk("mult_neg_hi", h, 32'hFFFF_FFFF);
    chk("mult_neg_lo", l, 32'hFFFF_FFFE);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, DIV_N);
    read_hilo(h, l);
    chk("div_hi", h, 32'hFFFF_FFFF);
    chk("div_lo", l, 32'hFFFF_FFFD);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N);
    read_hilo(h, l);
    chk("div_ovf_hi", h, 32'd0);
    chk("div_ovf_lo", l, 32'h8000_0000);

    step(1, 3'd5, 32'h1234, 32'd0, 0, 0, 0, 0);
    step(1, 3'd6, 32'h5678, 32'd0, 0, 1, 0, 0);
    chk("mthi_next", last_out, 32'h1234);
    step(1, 3'd4, 32'd99, 32'd0, 0, 0, 0, 0);
    chk("mtlo_next", last_out, 32'h5678);
    idle(DIV_N - 1);
    chk("divz_busy_last", 32'(last_busy), 32'd1);
    read_hilo(h, l);
    chk("divz_hi", h, 32'h1234);
    chk("divz_lo", l, 32'h5678);

    // stall window and ignored second start
    step(1, 3'd1, 32'd3, 32'd4, 1, 0, 0, 0);
    chk("stall_t0", 32'(last_stall), 32'd1);
    step(0, 3'd0, 32'd0, 32'd0, 1, 0, 0, 0);
    step(1, 3'd1, 32'd7, 32'd7, 1, 0, 0, 0);
    step(0, 3'd0, 32'd0, 32'd0, 1, 0, 0, 0);
    step(0, 3'd0, 32'd0, 32'd0, 1, 0, 0, 0);
    step(0, 3'd0, 32'd0, 32'd0, 1, 0, 0, 0);
    chk("stall_t5", 32'(last_stall), 32'd1);
    step(0, 3'd0, 32'd0, 32'd0, 1, 0, 0, 0);
    chk("stall_t6", 32'(last_stall), 32'd0);
    read_hilo(h, l);
    chk("ignored_hi", h, 32'd0);
    chk("ignored_lo", l, 32'd12);

    // reset mid-divide
    run_op(3'd4, 32'd100, 32'd7, 2);
    step(0, 3'd0, 32'd0, 32'd0, 0, 0, 0, 1);
    step(0, 3'd0, 32'd0, 32'd0, 0, 1, 0, 0);
    chk("rst_mid_busy", 32'(last_busy), 32'd0);
    chk("rst_mid_hi", last_out, 32'd0);
    idle(DIV_N);

    if (CANCEL_EN) begin
      run_op(3'd5, 32'hAAAA, 32'd0, 0);
      read_hilo(h0, l0);
      run_op(3'd1, 32'd5, 32'd6, 3);
      step(0, 3'd0, 32'd0, 32'd0, 0, 0, 1, 0);
      chk("cancel_busy_t4", 32'(last_busy), 32'd1);
      step(0, 3'd0, 32'd0, 32'd0, 0, 0, 0, 0);
      chk("cancel_busy_t5", 32'(last_busy), 32'd0);
      idle(3);
      read_hilo(h, l);
      chk("cancel_hi", h, h0);
      chk("cancel_lo", l, l0);
    end

    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), pick(), pick(),
           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
           CANCEL_EN && ($urandom_range(0, 15) == 0), logic'($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1);
  end
endmodule
